// File: rtl/llc_arbiter.sv
// llc_arbiter
// Shares the single cacheline-adaptor port between the L1 instruction cache
// and the L1 data cache. It grants one whole-line transaction at a time, using
// round-robin when both caches ask at once. Every output is registered.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   i_address_i/i_read_i            icache miss request
//   i_line_o/i_resp_o               icache returned line and completion pulse
//   d_address_i/d_read_i/d_write_i  dcache read or writeback request
//   d_line_i                        dcache writeback data
//   d_line_o/d_resp_o               dcache returned line and completion pulse
//   mem_address_o/mem_read_o/mem_write_o/mem_line_o  request to the adaptor
//   mem_line_i/mem_resp_i           adaptor returned line and completion pulse
//
// Handshake: a requester raises read/write and holds it (with stable address
// and data) until its x_resp_o pulse. It must drop the request in the cycle
// after that pulse. On the adaptor side, mem_read_o/mem_write_o stay high
// until the clock edge that samples mem_resp_i=1. They are low in the
// following cycle.
module llc_arbiter #(
  parameter int s_offset = 5,
  localparam int size = (2**s_offset)*8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [31:0]     i_address_i,
  input  logic            i_read_i,
  output logic [size-1:0] i_line_o,
  output logic            i_resp_o,
  input  logic [31:0]     d_address_i,
  input  logic            d_read_i,
  input  logic            d_write_i,
  input  logic [size-1:0] d_line_i,
  output logic [size-1:0] d_line_o,
  output logic            d_resp_o,
  output logic [31:0]     mem_address_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic [size-1:0] mem_line_o,
  input  logic [size-1:0] mem_line_i,
  input  logic            mem_resp_i
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  state_t          state, state_n;
  logic            last_d, last_d_n;  // 1: the dcache won the most recent grant
  logic [31:0]     address_n;
  logic [size-1:0] mem_line_n, i_line_n, d_line_n;
  logic            read_n, write_n, i_resp_n, d_resp_n;
  logic            i_req, d_req, grant_i;

  assign i_req = i_read_i;
  assign d_req = d_read_i | d_write_i;
  // The icache wins when alone, or on contention when the dcache went last.
  assign grant_i = i_req & (~d_req | last_d);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_d        <= 1'b1;
      mem_address_o <= '0;
      mem_read_o    <= 1'b0;
      mem_write_o   <= 1'b0;
      mem_line_o    <= '0;
      i_line_o      <= '0;
      d_line_o      <= '0;
      i_resp_o      <= 1'b0;
      d_resp_o      <= 1'b0;
    end else begin
      state         <= state_n;
      last_d        <= last_d_n;
      mem_address_o <= address_n;
      mem_read_o    <= read_n;
      mem_write_o   <= write_n;
      mem_line_o    <= mem_line_n;
      i_line_o      <= i_line_n;
      d_line_o      <= d_line_n;
      i_resp_o      <= i_resp_n;
      d_resp_o      <= d_resp_n;
    end
  end

  always_comb begin
    state_n    = state;
    last_d_n   = last_d;
    address_n  = mem_address_o;
    read_n     = mem_read_o;
    write_n    = mem_write_o;
    mem_line_n = mem_line_o;
    i_line_n   = i_line_o;
    d_line_n   = d_line_o;
    i_resp_n   = 1'b0;
    d_resp_n   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_i) begin
          address_n = i_address_i;
          read_n    = 1'b1;
          write_n   = 1'b0;
          last_d_n  = 1'b0;
          state_n   = BUSY_I;
        end else if (d_req) begin
          address_n  = d_address_i;
          mem_line_n = d_line_i;
          // Read wins when both are set, matching the adaptor's own priority.
          read_n     = d_read_i;
          write_n    = ~d_read_i & d_write_i;
          last_d_n   = 1'b1;
          state_n    = BUSY_D;
        end
      end
      BUSY_I: begin
        if (mem_resp_i) begin
          read_n   = 1'b0;
          write_n  = 1'b0;
          i_line_n = mem_line_i;
          i_resp_n = 1'b1;
          state_n  = RESP_I;
        end
      end
      BUSY_D: begin
        if (mem_resp_i) begin
          read_n  = 1'b0;
          write_n = 1'b0;
          if (mem_read_o) d_line_n = mem_line_i;
          d_resp_n = 1'b1;
          state_n  = RESP_D;
        end
      end
      // The response cycle never grants. The requester drops its request in
      // the IDLE cycle that follows, so it is not granted a second time.
      RESP_I, RESP_D: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_llc_arbiter.sv
// Testbench for llc_arbiter: directed scenarios followed by randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_llc_arbiter;
  localparam int SIZE = 256;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [31:0]     i_address_i = '0;
  logic            i_read_i = 1'b0;
  logic [SIZE-1:0] i_line_o;
  logic            i_resp_o;
  logic [31:0]     d_address_i = '0;
  logic            d_read_i = 1'b0;
  logic            d_write_i = 1'b0;
  logic [SIZE-1:0] d_line_i = '0;
  logic [SIZE-1:0] d_line_o;
  logic            d_resp_o;
  logic [31:0]     mem_address_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic [SIZE-1:0] mem_line_o;
  logic [SIZE-1:0] mem_line_i = '0;
  logic            mem_resp_i = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  int              own;      // 0 port free, 1 icache transaction, 2 dcache transaction
  bit              hold;     // one edge after a completion during which nobody is granted
  bit              last_d;   // dcache won the latest grant
  int              winner;
  int              lat;      // adaptor latency countdown, -1 when idle
  logic            e_rd, e_wr, e_iresp, e_dresp;
  logic [31:0]     e_addr;
  logic [SIZE-1:0] e_mline, e_iline, e_dline;

  llc_arbiter #(.s_offset(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_address_i(i_address_i), .i_read_i(i_read_i), .i_line_o(i_line_o), .i_resp_o(i_resp_o),
    .d_address_i(d_address_i), .d_read_i(d_read_i), .d_write_i(d_write_i),
    .d_line_i(d_line_i), .d_line_o(d_line_o), .d_resp_o(d_resp_o),
    .mem_address_o(mem_address_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_line_o(mem_line_o), .mem_line_i(mem_line_i), .mem_resp_i(mem_resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_read_i = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0; mem_resp_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_read"}, mem_read_o, 1'b0);
    check({tag, "_mem_write"}, mem_write_o, 1'b0);
    check({tag, "_mem_addr"}, mem_address_o, '0);
    check({tag, "_mem_line"}, mem_line_o, '0);
    check({tag, "_i_resp"}, i_resp_o, 1'b0);
    check({tag, "_d_resp"}, d_resp_o, 1'b0);
    check({tag, "_i_line"}, i_line_o, '0);
    check({tag, "_d_line"}, d_line_o, '0);
  endtask

  function automatic logic [SIZE-1:0] rand_line();
    logic [SIZE-1:0] v;
    for (int k = 0; k < SIZE/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    // ---- reset state
    do_reset();
    check_all_zero("reset");

    // ---- lone icache read: grant at cycle 1, adaptor completes in cycle 6
    i_address_i = 32'h0000_1200; i_read_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check("icache_mem_read_high", mem_read_o, 1'b1);
      check("icache_resp_early", i_resp_o, 1'b0);
    end
    check("icache_addr", mem_address_o, 32'h0000_1200);
    check("icache_no_write", mem_write_o, 1'b0);
    mem_line_i = {32{8'hA5}}; mem_resp_i = 1'b1;
    tick();  // cycle 7: response cycle
    mem_resp_i = 1'b0; i_read_i = 1'b0;
    check("icache_resp", i_resp_o, 1'b1);
    check("icache_mem_read_low", mem_read_o, 1'b0);
    check("icache_line", i_line_o, {32{8'hA5}});
    check("icache_dline_kept", d_line_o, '0);
    check("icache_no_dresp", d_resp_o, 1'b0);
    tick();
    check("icache_resp_one_cycle", i_resp_o, 1'b0);
    tick();
    check("icache_no_regrant", mem_read_o, 1'b0);

    // ---- dcache writeback
    d_address_i = 32'h8000_0040; d_line_i = {16{16'h1234}}; d_write_i = 1'b1;
    tick();
    check("wb_mem_write", mem_write_o, 1'b1);
    check("wb_mem_read", mem_read_o, 1'b0);
    check("wb_addr", mem_address_o, 32'h8000_0040);
    check("wb_line", mem_line_o, {16{16'h1234}});
    d_line_i = '1;  // must be ignored while the transaction runs
    tick();
    check("wb_line_held", mem_line_o, {16{16'h1234}});
    mem_line_i = {32{8'h3C}}; mem_resp_i = 1'b1;
    tick();
    mem_resp_i = 1'b0; d_write_i = 1'b0;
    check("wb_resp", d_resp_o, 1'b1);
    check("wb_mem_write_low", mem_write_o, 1'b0);
    check("wb_dline_kept", d_line_o, '0);
    check("wb_iline_kept", i_line_o, {32{8'hA5}});
    tick();
    check("wb_resp_one_cycle", d_resp_o, 1'b0);

    // ---- dcache read and write together behave as a read
    d_address_i = 32'h0000_0040; d_read_i = 1'b1; d_write_i = 1'b1;
    tick();
    check("both_mem_read", mem_read_o, 1'b1);
    check("both_mem_write", mem_write_o, 1'b0);
    mem_line_i = {8{32'hDEAD_BEEF}}; mem_resp_i = 1'b1;
    tick();
    mem_resp_i = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0;
    check("both_resp", d_resp_o, 1'b1);
    check("both_dline", d_line_o, {8{32'hDEAD_BEEF}});
    tick();

    // ---- asynchronous reset in the middle of a writeback
    d_address_i = 32'h0000_0080; d_line_i = {8{32'h5555_AAAA}}; d_write_i = 1'b1;
    tick();
    check("rst_pre_write", mem_write_o, 1'b1);
    #2 reset_n = 1'b0; d_write_i = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk); reset_n = 1'b1;
    tick();
    check("rst_after_write", mem_write_o, 1'b0);
    check("rst_after_dresp", d_resp_o, 1'b0);
    tick();
    check("rst_after_dresp2", d_resp_o, 1'b0);

    // ---- contention from reset: icache, then dcache, then icache again
    do_reset();
    i_address_i = 32'h100; d_address_i = 32'h200; i_read_i = 1'b1; d_read_i = 1'b1;
    tick();
    check("rr1_addr", mem_address_o, 32'h100);
    check("rr1_read", mem_read_o, 1'b1);
    mem_line_i = {8{32'h1111_2222}}; mem_resp_i = 1'b1;
    tick();
    mem_resp_i = 1'b0; i_read_i = 1'b0;
    check("rr1_iresp", i_resp_o, 1'b1);
    tick();  // idle cycle; a stray adaptor pulse here must be ignored
    check("rr_idle_read", mem_read_o, 1'b0);
    mem_resp_i = 1'b1; mem_line_i = {8{32'h3333_4444}};
    tick();
    check("rr2_addr", mem_address_o, 32'h200);
    check("rr2_read", mem_read_o, 1'b1);
    check("rr2_stray_ignored", d_resp_o, 1'b0);
    tick();
    mem_resp_i = 1'b0; d_read_i = 1'b0;
    check("rr2_dresp", d_resp_o, 1'b1);
    check("rr2_dline", d_line_o, {8{32'h3333_4444}});
    check("rr2_iline_kept", i_line_o, {8{32'h1111_2222}});
    tick();
    i_address_i = 32'h300; d_address_i = 32'h400; i_read_i = 1'b1; d_read_i = 1'b1;
    tick();
    check("rr3_addr", mem_address_o, 32'h300);
    mem_resp_i = 1'b1;
    tick();
    mem_resp_i = 1'b0; i_read_i = 1'b0;
    check("rr3_iresp", i_resp_o, 1'b1);
    tick();
    tick();
    check("rr4_addr", mem_address_o, 32'h400);
    mem_resp_i = 1'b1;
    tick();
    mem_resp_i = 1'b0; d_read_i = 1'b0;
    check("rr4_dresp", d_resp_o, 1'b1);

    // ---- randomized traffic against the reference model
    do_reset();
    own = 0; hold = 1'b0; last_d = 1'b1; lat = -1;
    e_rd = 1'b0; e_wr = 1'b0; e_iresp = 1'b0; e_dresp = 1'b0;
    e_addr = '0; e_mline = '0; e_iline = '0; e_dline = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) tick();
      check("rand_mem_read", mem_read_o, e_rd);
      check("rand_mem_write", mem_write_o, e_wr);
      check("rand_mem_addr", mem_address_o, e_addr);
      check("rand_mem_line", mem_line_o, e_mline);
      check("rand_i_resp", i_resp_o, e_iresp);
      check("rand_d_resp", d_resp_o, e_dresp);
      check("rand_i_line", i_line_o, e_iline);
      check("rand_d_line", d_line_o, e_dline);

      // icache agent
      if (i_resp_o) i_read_i = 1'b0;
      else if (!i_read_i && $urandom_range(0, 2) == 0) begin
        i_address_i = $urandom; i_read_i = 1'b1;
      end
      // dcache agent
      if (d_resp_o) begin
        d_read_i = 1'b0; d_write_i = 1'b0;
      end else if (!(d_read_i | d_write_i) && $urandom_range(0, 2) == 0) begin
        d_address_i = $urandom;
        case ($urandom_range(0, 2))
          0: begin d_read_i = 1'b1; d_write_i = 1'b0; end
          1: begin d_read_i = 1'b0; d_write_i = 1'b1; end
          default: begin d_read_i = 1'b1; d_write_i = 1'b1; end
        endcase
      end
      d_line_i = rand_line();
      // adaptor: random latency when busy, occasional stray pulses when not
      mem_line_i = rand_line();
      if (mem_read_o | mem_write_o) begin
        if (lat < 0) lat = $urandom_range(0, 4);
        if (lat == 0) begin mem_resp_i = 1'b1; lat = -1; end
        else begin mem_resp_i = 1'b0; lat--; end
      end else mem_resp_i = ($urandom_range(0, 5) == 0);

      // reference model: effect of the coming clock edge
      e_iresp = 1'b0; e_dresp = 1'b0;
      if (own != 0) begin
        if (mem_resp_i) begin
          if (own == 1) begin
            e_iline = mem_line_i; e_iresp = 1'b1;
          end else begin
            if (e_rd) e_dline = mem_line_i;
            e_dresp = 1'b1;
          end
          e_rd = 1'b0; e_wr = 1'b0; own = 0; hold = 1'b1;
        end
      end else if (hold) hold = 1'b0;
      else begin
        if (i_read_i && (d_read_i | d_write_i)) winner = last_d ? 1 : 2;
        else if (i_read_i) winner = 1;
        else if (d_read_i | d_write_i) winner = 2;
        else winner = 0;
        if (winner == 1) begin
          e_addr = i_address_i; e_rd = 1'b1; e_wr = 1'b0; own = 1; last_d = 1'b0;
        end else if (winner == 2) begin
          e_addr = d_address_i; e_mline = d_line_i;
          e_rd = d_read_i; e_wr = ~d_read_i; own = 2; last_d = 1'b1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
